// File: rtl/pc_sequencer.sv
// pc_sequencer: PC fetch FSM; drives pc_sel/jump_dir, fetches over imem req/ack, issues instr over valid/ready, queues one jump, flags fetch timeout
module pc_sequencer #(
  parameter int N = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc_i,
  output logic [1:0]   pc_sel,
  output logic [N-1:0] jump_dir,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jump_req,
  input  logic [N-1:0] jump_target,
  input  logic         halt,
  output logic         fetch_err
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {INIT, FETCH, ISSUE, ADVANCE, HALT, FAULT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic pend;
  logic [N-1:0] pend_t;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT;
      instr  <= '0;
      pend   <= 1'b0;
      pend_t <= '0;
      cnt    <= '0;
    end else begin
      if ((state == FETCH || state == ISSUE || state == HALT) && jump_req) begin
        pend   <= 1'b1;
        pend_t <= jump_target;
      end
      case (state)
        INIT: begin
          state <= FETCH;
          cnt   <= '0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= ISSUE;
          end else if (cnt == CW'(TIMEOUT - 1)) state <= FAULT;
          else cnt <= cnt + CW'(1);
        end
        ISSUE: if (instr_ready) state <= ADVANCE;
        ADVANCE: begin
          pend  <= 1'b0;
          cnt   <= '0;
          state <= halt ? HALT : FETCH;
        end
        HALT: begin
          if (!halt) begin
            state <= FETCH;
            cnt   <= '0;
          end
        end
        default: state <= FAULT;
      endcase
    end
  end
  assign pc_sel      = state == INIT ? 2'b00 : state == ADVANCE ? {1'b1, pend | jump_req} : 2'b01;
  assign jump_dir    = (state == ADVANCE && jump_req) ? jump_target : pend_t;
  assign imem_req    = state == FETCH;
  assign imem_addr   = pc_i;
  assign instr_valid = state == ISSUE;
  assign fetch_err   = state == FAULT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized transaction-level check of pc_sequencer against a last-jump-wins PC model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc;
  logic [1:0] pc_sel;
  logic [31:0] jump_dir, imem_addr, imem_rdata, instr, jump_target;
  logic imem_req, imem_ack, instr_valid, instr_ready, jump_req, halt, fetch_err;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  bit pend;
  logic [31:0] pend_t;
  always #5 clk = ~clk;
  pc_sequencer #(.N(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .pc_sel(pc_sel), .jump_dir(jump_dir),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_req(jump_req), .jump_target(jump_target), .halt(halt), .fetch_err(fetch_err)
  );
  always_ff @(posedge clk)
    pc <= pc_sel == 2'b00 ? 32'h0 : pc_sel == 2'b01 ? pc : pc_sel == 2'b10 ? pc + 32'd4 : jump_dir;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic jmp(input bit en, input logic [31:0] t);
    jump_req = en;
    jump_target = en ? t : $urandom;
    if (en) begin
      pend = 1'b1;
      pend_t = t;
    end
  endtask
  task automatic txn(input int ad, input int rd, input bit h, input int hold,
                     input logic [31:0] tf, input logic [31:0] ti, input logic [31:0] ta, input logic [31:0] th,
                     input bit jf, input bit ji, input bit ja, input bit jh);
    for (int i = 0; i <= ad; i++) begin
      chk("fetch_req", imem_req, 1);
      chk("fetch_sel", pc_sel, 1);
      chk("fetch_addr", imem_addr, exp_pc);
      chk("fetch_valid", instr_valid, 0);
      chk("fetch_err", fetch_err, 0);
      jmp(jf && i == 0, tf);
      imem_ack = i == ad;
      imem_rdata = mem(imem_addr);
      @(negedge clk);
    end
    jump_req = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i <= rd; i++) begin
      chk("issue_valid", instr_valid, 1);
      chk("issue_sel", pc_sel, 1);
      chk("issue_req", imem_req, 0);
      chk("issue_instr", instr, mem(exp_pc));
      jmp(ji && i == 0, ti);
      instr_ready = i == rd;
      @(negedge clk);
    end
    instr_ready = 1'b0;
    jmp(ja, ta);
    halt = h;
    #1;
    chk("adv_sel", pc_sel, pend ? 2'b11 : 2'b10);
    if (pend) chk("adv_dir", jump_dir, pend_t);
    exp_pc = pend ? pend_t : exp_pc + 32'd4;
    pend = 1'b0;
    @(negedge clk);
    jump_req = 1'b0;
    if (h) begin
      for (int j = 0; j <= hold; j++) begin
        chk("halt_sel", pc_sel, 1);
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
        jmp(jh && j == 0, th);
        halt = j < hold;
        @(negedge clk);
      end
      jump_req = 1'b0;
    end
  endtask
  initial begin
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    jump_req = 1'b0;
    jump_target = '0;
    halt = 1'b0;
    pend = 1'b0;
    pend_t = '0;
    exp_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_sel", pc_sel, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_dir", jump_dir, 0);
    chk("rst_instr", instr, 0);
    rst = 1'b0;
    #1 chk("init_sel", pc_sel, 0);
    @(negedge clk);
    repeat (4) txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 1, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(1, 0, 0, 0, 32'h80, 0, 32'h90, 0, 1, 0, 1, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 0, 1, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 1, 3, 0, 0, 0, 32'h200, 0, 0, 0, 1);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 200; k++)
      txn($urandom_range(3), $urandom_range(3), $urandom_range(7) == 0, $urandom_range(2),
          $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC,
          $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(1) == 0);
    jump_req = 1'b1;
    jump_target = 32'h300;
    imem_ack = 1'b1;
    imem_rdata = mem(imem_addr);
    @(negedge clk);
    jump_req = 1'b0;
    imem_ack = 1'b0;
    chk("pre_rst_valid", instr_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_sel", pc_sel, 0);
    chk("arst_dir", jump_dir, 0);
    chk("arst_instr", instr, 0);
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0;
    exp_pc = '0;
    @(negedge clk);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("to_wait_err", fetch_err, 0);
      chk("to_wait_req", imem_req, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk("to_err", fetch_err, 1);
      chk("to_sel", pc_sel, 1);
      chk("to_req", imem_req, 0);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch controller for the microprocessor's program counter. It drives the 2-bit `pc_sel` and the jump address of the PC register, and fetches each instruction over a req/ack memory handshake. It presents the fetched word to the core with a valid/ready handshake. It also queues jump requests from the execute stage and reports memory fetch timeouts.

## Interface
- `N`, 32: address width; must match the PC register width.
- `TIMEOUT`, 16: maximum cycles spent in FETCH without `imem_ack` before faulting; must be ≥ 1.

- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_i`  in  N  current PC register value.
- `pc_sel`  out  2  PC command: 00 clear, 01 hold, 10 PC+4, 11 load `jump_dir`.
- `jump_dir`  out  N  jump address for the PC register.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  N  fetch address; always equals `pc_i`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `instr`  out  32  registered instruction for the core.
- `instr_valid`  out  1  `instr` is available.
- `instr_ready`  in  1  core accepts `instr`.
- `jump_req`  in  1  one-cycle jump request from execute.
- `jump_target`  in  N  jump address, sampled together with `jump_req`.
- `halt`  in  1  stop fetching after the current instruction.
- `fetch_err`  out  1  sticky fault flag.

## Operation
The FSM has six states: INIT, FETCH, ISSUE, ADVANCE, HALT, FAULT. `pc_sel`, `imem_req`, `instr_valid` and `fetch_err` are decoded combinationally from the state.

**INIT**
- Entered on `rst`. Outputs `pc_sel`=00.
- Always goes to FETCH on the next edge.

**FETCH**
- Outputs `imem_req`=1 and `pc_sel`=01.
- On `imem_ack`: latch `imem_rdata` into `instr`, then go to ISSUE.
- The timeout counter clears on entry and increments each FETCH cycle without `imem_ack`.
- If the counter equals `TIMEOUT`-1 and there is no ack, go to FAULT. An ack in that same cycle takes priority.

**ISSUE**
- Outputs `instr_valid`=1 and `pc_sel`=01. `instr` is stable.
- On `instr_ready`, go to ADVANCE.

**ADVANCE** (exactly one cycle)
- Drives `pc_sel`=11 if a jump is pending or `jump_req` is high this cycle; otherwise `pc_sel`=10.
- Clears the pending jump.
- Next state is HALT if `halt`=1, otherwise FETCH.

**HALT**
- Outputs `pc_sel`=01.
- Returns to FETCH in the cycle after `halt` is sampled low.

**FAULT**
- Outputs `pc_sel`=01 and `fetch_err`=1.
- Exits only via `rst`.

**Jump queue**
- There is one pending slot: a pending flag plus a target register.
- `jump_req` is captured in FETCH, ISSUE and HALT.
- A later request overwrites an earlier one (last wins).
- `jump_req` is ignored in INIT and FAULT.
- In ADVANCE, a live `jump_req` takes priority over the pending target: `jump_dir` = `jump_target` combinationally.
- Otherwise `jump_dir` equals the pending target register.

## Timing
**Values while `rst` is high**
- Outputs: `pc_sel`=00, `imem_req`=0, `instr_valid`=0, `fetch_err`=0, `jump_dir`=0.
- Registers: `instr`=0, pending flag=0, timeout counter=0.

**Cycle counts**
- The PC register clears on the first edge in INIT.
- `imem_req` rises in the cycle after INIT.
- Minimum instruction period is 3 cycles (FETCH, ISSUE, ADVANCE), reached with a zero-wait ack and `instr_ready` held high.
- Each cycle of memory wait adds one cycle in FETCH. Each cycle of core stall adds one cycle in ISSUE.
- The new PC is visible on `pc_i` in the cycle after ADVANCE, which is the first FETCH cycle. `imem_addr` therefore always carries the updated PC.

**Other rules**
- PC+4 wraps modulo 2^N. The sequencer does not detect the wrap.
- Asserting `rst` mid-fetch or mid-issue immediately forces INIT: `instr_valid` and `imem_req` drop asynchronously, and any pending jump is discarded.

## Test plan
- **Reset and straight-line fetch.** Reset, then `imem_ack` tied to `imem_req`, `instr_ready`=1 → `pc_sel` sequence 00, 01, 01, 10, 01…; `imem_addr` = 0, 4, 8 every 3 cycles; `instr` matches memory.
- **Queued jump.** `jump_req` pulse with `jump_target`=0x40 during ISSUE → next ADVANCE drives `pc_sel`=11, `jump_dir`=0x40; next `imem_addr`=0x40; the following ADVANCE drives 10.
- **Jump in ADVANCE and last-wins.** `jump_req`=0x80 in FETCH, then `jump_req`=0x90 in the ADVANCE cycle → `jump_dir`=0x90; after 0x90 is taken, a further ADVANCE with no new `jump_req` drives `pc_sel`=10.
- **Stalls.** `imem_ack` delayed 3 cycles and `instr_ready` delayed 2 cycles → `imem_req` held 4 cycles and `instr_valid` held 3 cycles; `pc_sel`=01 throughout; `instr` stable during ISSUE.
- **Timeout.** `TIMEOUT`=4 with no ack → `fetch_err`=1 in the 5th cycle after FETCH entry, then stays high and `pc_sel`=01. A separate run with ack in the 4th FETCH cycle → no fault.
- **Halt and async reset.** `halt`=1 at ADVANCE → HALT state with `pc_sel`=01; a jump request captured during HALT is taken after `halt` drops. Separately, `rst` pulsed mid-ISSUE → `instr_valid`=0 immediately, `pc_sel`=00, and fetch resumes at address 0.
